// File: rtl/key_debounce_pulse.sv
// Key input conditioner: per-key 2-flop synchroniser, debounce FSM,
// single-cycle press pulse and debounced level.
module key_debounce_pulse #(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter bit          KEY_ACTIVE_HIGH = 1'b1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_pulse,
  output logic [NUM_KEYS-1:0] key_level,
  output logic                any_level
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [NUM_KEYS-1:0] KEY_INV = KEY_ACTIVE_HIGH ? '0 : '1;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  logic [NUM_KEYS-1:0] key_meta;
  logic [NUM_KEYS-1:0] key_s;
  state_t              state     [NUM_KEYS];
  state_t              state_nxt [NUM_KEYS];
  logic [CNT_W-1:0]    cnt       [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_nxt   [NUM_KEYS];
  logic [NUM_KEYS-1:0] pulse_nxt;
  logic [NUM_KEYS-1:0] level_nxt;

  // Normalise polarity so pressed is always 1, then synchronise.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      key_meta <= '0;
      key_s    <= '0;
    end else begin
      key_meta <= key_raw ^ KEY_INV;
      key_s    <= key_meta;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
      key_pulse <= '0;
      key_level <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
      key_pulse <= pulse_nxt;
      key_level <= level_nxt;
    end
  end

  // Per-channel next state; the level follows the next state so it rises with the pulse.
  always_comb begin
    pulse_nxt = '0;
    level_nxt = '0;
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = cnt[i];
      case (state[i])
        IDLE: begin
          if (key_s[i]) begin
            state_nxt[i] = PRESS_CHK;
            cnt_nxt[i]   = '0;
          end
        end
        PRESS_CHK: begin
          if (!key_s[i]) begin
            state_nxt[i] = IDLE;
          end else if (cnt[i] == CNT_LAST) begin
            state_nxt[i] = PRESSED;
            pulse_nxt[i] = 1'b1;
          end else begin
            cnt_nxt[i] = cnt[i] + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!key_s[i]) begin
            state_nxt[i] = RELEASE_CHK;
            cnt_nxt[i]   = '0;
          end
        end
        RELEASE_CHK: begin
          if (key_s[i]) begin
            state_nxt[i] = PRESSED;
          end else if (cnt[i] == CNT_LAST) begin
            state_nxt[i] = IDLE;
          end else begin
            cnt_nxt[i] = cnt[i] + CNT_W'(1);
          end
        end
        default: state_nxt[i] = IDLE;
      endcase
      level_nxt[i] = (state_nxt[i] == PRESSED) || (state_nxt[i] == RELEASE_CHK);
    end
  end

  assign any_level = |key_level;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Directed bench for key_debounce_pulse with DEBOUNCE_CYCLES=4, one
// active-high and one active-low instance.
module tb_key_debounce_pulse;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [3:0] key_a = 4'b0000;
  logic [3:0] key_b = 4'b1111;
  logic [3:0] pulse_a, level_a, pulse_b, level_b;
  logic       any_a, any_b;
  int         total = 0;
  int         bad = 0;
  int         npulse;

  always #5 clk = ~clk;

  key_debounce_pulse #(.NUM_KEYS(4), .DEBOUNCE_CYCLES(4), .KEY_ACTIVE_HIGH(1'b1)) dut_a (
    .clk(clk), .n_rst(n_rst), .key_raw(key_a),
    .key_pulse(pulse_a), .key_level(level_a), .any_level(any_a)
  );

  key_debounce_pulse #(.NUM_KEYS(4), .DEBOUNCE_CYCLES(4), .KEY_ACTIVE_HIGH(1'b0)) dut_b (
    .clk(clk), .n_rst(n_rst), .key_raw(key_b),
    .key_pulse(pulse_b), .key_level(level_b), .any_level(any_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Edge k is the k-th rising edge after stimulus is applied; sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_pulse_a", 32'(pulse_a), 0);
    chk("rst_level_a", 32'(level_a), 0);
    chk("rst_any_a", 32'(any_a), 0);
    chk("rst_pulse_b", 32'(pulse_b), 0);
    chk("rst_level_b", 32'(level_b), 0);
    chk("rst_any_b", 32'(any_b), 0);
    n_rst = 1'b1;
    repeat (3) tick();

    // Clean press held for 200 cycles
    key_a = 4'b0001;
    npulse = 0;
    for (int e = 1; e <= 200; e++) begin
      tick();
      if (pulse_a[0]) npulse++;
      if (e <= 8) begin
        chk("press_pulse", 32'(pulse_a[0]), 32'(e == 7));
        chk("press_level", 32'(level_a[0]), 32'(e >= 7));
        chk("press_any", 32'(any_a), 32'(e >= 7));
      end
    end
    chk("hold_pulse_count", 32'(npulse), 1);

    // Clean release
    key_a = 4'b0000;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk("rel_pulse", 32'(pulse_a[0]), 0);
      chk("rel_level", 32'(level_a[0]), 32'(e < 7));
    end
    repeat (3) tick();

    // Release bounce while pressed
    key_a = 4'b0001;
    repeat (8) tick();
    chk("bounce_pre_level", 32'(level_a[0]), 1);
    key_a = 4'b0000;
    repeat (2) tick();
    key_a = 4'b0001;
    for (int e = 1; e <= 15; e++) begin
      tick();
      chk("bounce_pulse", 32'(pulse_a[0]), 0);
      chk("bounce_level", 32'(level_a[0]), 1);
    end
    key_a = 4'b0000;
    repeat (10) tick();
    chk("bounce_post_level", 32'(level_a), 0);

    // Short glitch on key 1
    key_a = 4'b0010;
    for (int e = 1; e <= 15; e++) begin
      tick();
      if (e == 3) key_a = 4'b0000;
      chk("glitch_pulse", 32'(pulse_a[1]), 0);
      chk("glitch_level", 32'(level_a[1]), 0);
    end

    // Simultaneous press on keys 0 and 3
    key_a = 4'b1001;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk("simul_pulse", 32'(pulse_a), (e == 7) ? 32'h9 : 32'h0);
    end
    key_a = 4'b0000;
    repeat (10) tick();

    // Reset while key 2 is mid-debounce and key 0 is pressed
    key_a = 4'b0001;
    repeat (10) tick();
    chk("pre_rst_level", 32'(level_a), 32'h1);
    key_a = 4'b0101;
    repeat (5) tick();
    n_rst = 1'b0;
    #1;
    chk("midrst_level", 32'(level_a), 0);
    chk("midrst_pulse", 32'(pulse_a), 0);
    chk("midrst_any", 32'(any_a), 0);
    repeat (2) tick();
    n_rst = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk("postrst_pulse", 32'(pulse_a), (e == 7) ? 32'h5 : 32'h0);
      chk("postrst_level", 32'(level_a), (e >= 7) ? 32'h5 : 32'h0);
    end
    key_a = 4'b0000;
    repeat (10) tick();

    // Active-low instance: pressed when raw is low
    chk("actlow_idle", 32'(level_b), 0);
    key_b = 4'b1110;
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk("actlow_pulse", 32'(pulse_b), (e == 7) ? 32'h1 : 32'h0);
      chk("actlow_level", 32'(level_b[0]), 32'(e >= 7));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
